// File: rtl/seven_segment_quad.sv
// Four-digit seven-segment driver for the Mastermind board: decodes 3-bit digits,
// applies per-digit blanking and a blinking cursor, and registers every HEX output.
module seven_segment_quad #(
    parameter int unsigned BLINK_DIV  = 25_000_000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic       MAX10_CLK1_50,
    input  logic       reset_n,
    input  logic [2:0] d0,
    input  logic [2:0] d1,
    input  logic [2:0] d2,
    input  logic [2:0] d3,
    input  logic [3:0] blank,
    input  logic [1:0] cursor,
    input  logic       blink_en,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3
);

    localparam int unsigned    CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [6:0]     DARK     = ACTIVE_LOW ? 7'h7F : 7'h00;

    // Segment patterns are stored active-low (g..a) and inverted for active-high boards.
    function automatic logic [6:0] decode(input logic [2:0] v);
        logic [6:0] seg;
        case (v)
            3'd0:    seg = 7'h40;
            3'd1:    seg = 7'h79;
            3'd2:    seg = 7'h24;
            3'd3:    seg = 7'h30;
            3'd4:    seg = 7'h19;
            3'd5:    seg = 7'h12;
            3'd6:    seg = 7'h02;
            default: seg = 7'h78;
        endcase
        return ACTIVE_LOW ? seg : ~seg;
    endfunction

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [3:0][6:0]  hex_q, hex_d;
    logic [3:0][2:0]  digit;

    assign digit = {d3, d2, d1, d0};

    // NOTE: defaults come first in every always_comb so no path leaves a signal unassigned (no latches).
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        phase_d = phase_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    // Blanking wins over the cursor blink; phase 0 is the dark half of the blink.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            hex_d[k] = decode(digit[k]);
            if (blank[k]) begin
                hex_d[k] = DARK;
            end else if (blink_en && (cursor == 2'(k)) && !phase_q) begin
                hex_d[k] = DARK;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
            hex_q   <= {4{DARK}};
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            hex_q   <= hex_d;
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];

endmodule

// File: tb/tb_seven_segment_quad.sv
// Bench for seven_segment_quad: an active-low and an active-high instance share the
// same stimulus and are compared against an edge-counting reference model.
module tb_seven_segment_quad;

    localparam int unsigned DIV = 4;

    logic       clk;
    logic       reset_n;
    logic [2:0] d0, d1, d2, d3;
    logic [3:0] blank;
    logic [1:0] cursor;
    logic       blink_en;
    logic [6:0] hex0, hex1, hex2, hex3;
    logic [6:0] inv0, inv1, inv2, inv3;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int unsigned edges        = 0;

    logic [6:0] seg_lut [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

    seven_segment_quad #(.BLINK_DIV(DIV), .ACTIVE_LOW(1'b1)) dut_low (
        .MAX10_CLK1_50(clk), .reset_n(reset_n),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .blank(blank), .cursor(cursor), .blink_en(blink_en),
        .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3)
    );

    seven_segment_quad #(.BLINK_DIV(DIV), .ACTIVE_LOW(1'b0)) dut_high (
        .MAX10_CLK1_50(clk), .reset_n(reset_n),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .blank(blank), .cursor(cursor), .blink_en(blink_en),
        .HEX0(inv0), .HEX1(inv1), .HEX2(inv2), .HEX3(inv3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected active-low outputs after the next edge, given n edges already elapsed since release.
    function automatic logic [27:0] model(input int unsigned n);
        logic [27:0] r;
        int          vals [4];
        bit          visible;
        visible = ((n / DIV) % 2) == 0;
        vals    = '{int'(d0), int'(d1), int'(d2), int'(d3)};
        r       = '0;
        for (int k = 0; k < 4; k++) begin
            if (blank[k])                                    r[k*7 +: 7] = 7'h7F;
            else if (blink_en && int'(cursor) == k && !visible) r[k*7 +: 7] = 7'h7F;
            else                                             r[k*7 +: 7] = seg_lut[vals[k]];
        end
        return r;
    endfunction

    task automatic tick(input string name);
        logic [27:0] exp;
        exp = model(edges);
        @(posedge clk);
        #1;
        edges++;
        tests_run++;
        if ({hex3, hex2, hex1, hex0} !== exp) begin
            tests_failed++;
            $display("FAIL %s (low) edge %0d: got %h expected %h", name, edges, {hex3, hex2, hex1, hex0}, exp);
        end
        tests_run++;
        if ({inv3, inv2, inv1, inv0} !== ~exp) begin
            tests_failed++;
            $display("FAIL %s (high) edge %0d: got %h expected %h", name, edges, {inv3, inv2, inv1, inv0}, ~exp);
        end
    endtask

    task automatic check7(input string name, input logic [6:0] got, input logic [6:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_dark(input string name);
        tests_run++;
        if ({hex3, hex2, hex1, hex0} !== {4{7'h7F}}) begin
            tests_failed++;
            $display("FAIL %s (low): got %h expected all 7f", name, {hex3, hex2, hex1, hex0});
        end
        tests_run++;
        if ({inv3, inv2, inv1, inv0} !== 28'h0) begin
            tests_failed++;
            $display("FAIL %s (high): got %h expected all 00", name, {inv3, inv2, inv1, inv0});
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        edges   = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        {d0, d1, d2, d3} = {3'd1, 3'd2, 3'd3, 3'd4};
        blank = 4'b0; cursor = 2'd0; blink_en = 1'b0;
        #12;
        check_dark("reset_dark");
        release_reset();
        tick("reset_release");
        check7("reset_hex0", hex0, 7'h79);
        check7("reset_hex1", hex1, 7'h24);
        check7("reset_hex2", hex2, 7'h30);
        check7("reset_hex3", hex3, 7'h19);
    endtask

    task automatic test_decode_sweep();
        blank = 4'b0; blink_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int v = 0; v < 8; v++) begin
                case (k)
                    0: d0 = 3'(v);
                    1: d1 = 3'(v);
                    2: d2 = 3'(v);
                    default: d3 = 3'(v);
                endcase
                tick("decode_sweep");
            end
        end
        d0 = 3'd0;
        tick("decode_zero");
        check7("decode_zero_high", inv0, 7'h3F);
    endtask

    task automatic test_blanking();
        d0 = 3'd1; d1 = 3'd2; d2 = 3'd5; d3 = 3'd7;
        blank = 4'b0100;
        tick("blank_set");
        check7("blank_hex2", hex2, 7'h7F);
        check7("blank_hex0_unaffected", hex0, 7'h79);
        blank = 4'b0000;
        tick("blank_clear");
        check7("blank_clear_hex2", hex2, 7'h12);
    endtask

    task automatic test_blink();
        reset_n = 1'b0;
        #3;
        d0 = 3'd0; d1 = 3'd6; d2 = 3'd3; d3 = 3'd7;
        blank = 4'b0; cursor = 2'd1; blink_en = 1'b1;
        release_reset();
        for (int i = 1; i <= 4; i++) tick("blink_lit");
        check7("blink_edge4_lit", hex1, 7'h02);
        tick("blink_first_dark");
        check7("blink_edge5_dark", hex1, 7'h7F);
        tick("blink_dark");
        cursor = 2'd3;
        tick("cursor_move");
        check7("cursor_move_hex1", hex1, 7'h02);
        check7("cursor_move_hex3", hex3, 7'h7F);
        for (int i = 0; i < 9; i++) tick("blink_run");
    endtask

    task automatic test_priority();
        blank = 4'b0010; cursor = 2'd1; blink_en = 1'b1;
        for (int i = 0; i < 2 * DIV + 2; i++) begin
            tick("priority");
            check7("priority_hex1", hex1, 7'h7F);
        end
        blank = 4'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            d0 = 3'($urandom); d1 = 3'($urandom); d2 = 3'($urandom); d3 = 3'($urandom);
            blank    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            cursor   = 2'($urandom);
            blink_en = ($urandom_range(0, 2) != 0);
            tick("random");
        end
    endtask

    task automatic test_async_reset();
        tick("pre_reset");
        #2;
        reset_n = 1'b0;
        #1;
        check_dark("async_reset_dark");
        d0 = 3'd2; d1 = 3'd6; d2 = 3'd4; d3 = 3'd5;
        blank = 4'b0; cursor = 2'd1; blink_en = 1'b1;
        release_reset();
        for (int i = 1; i <= 4; i++) tick("restart_lit");
        check7("restart_edge4_lit", hex1, 7'h02);
        tick("restart_dark");
        check7("restart_edge5_dark", hex1, 7'h7F);
    endtask

    initial begin
        test_reset();
        test_decode_sweep();
        test_blanking();
        test_blink();
        test_priority();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seven_segment_quad.md
# seven_segment_quad

Four-digit seven-segment display driver for the Mastermind board top level. Decodes four 3-bit guess digits (values 0–7) into the DE10-Lite HEX0–HEX3 segment patterns. Supports per-digit blanking and an optional blinking cursor on the digit currently being edited. All outputs are registered in one clock domain.

## Interface
Parameters:
- BLINK_DIV, default 25_000_000: cursor blink half-period in clock cycles (0.5 s at 50 MHz); legal range ≥ 2.
- ACTIVE_LOW, default 1: 1 means a lit segment drives 0 (DE10-Lite); 0 inverts every HEX bit.

Ports (one clock; reset is asynchronous and active-low):
- MAX10_CLK1_50, input, 1: system clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- d0, d1, d2, d3, input, 3 each: digit values; d0→HEX0 … d3→HEX3.
- blank, input, 4: blank[k]=1 forces HEXk dark.
- cursor, input, 2: index (0–3) of the digit being edited.
- blink_en, input, 1: 1 makes the cursor digit blink.
- HEX0, HEX1, HEX2, HEX3, output, 7 each: segment drives; bit0=a, bit1=b, … bit6=g.

## Operation
- Decode (ACTIVE_LOW=1, written g..a as hex): 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19, 5→0x12, 6→0x02, 7→0x78. Dark (blank) pattern is 0x7F.
- ACTIVE_LOW=0: every pattern is bitwise inverted, so dark is 0x00.
- Blink generator:
  - Counter runs from 0 to BLINK_DIV−1. At the terminal count it wraps to 0 and toggles `phase`.
  - The counter free-runs regardless of blink_en.
- Per digit k, in priority order:
  - blank[k]=1 → dark.
  - Otherwise blink_en=1 and cursor==k and phase=0 → dark.
  - Otherwise → decode(dk).
- Only one digit at a time can be cursor-blanked. Non-cursor digits never blink.
- Inputs are sampled every cycle; the design has no handshake.
- Changing cursor mid-phase moves the blanking immediately on the next registered update. The phase is not restarted.
- All four digits use identical decode logic; there are no priority interactions between digits.

## Timing
- Reset (reset_n=0, asynchronous):
  - HEX0–HEX3 go dark immediately (0x7F; 0x00 if ACTIVE_LOW=0).
  - Blink counter = 0, phase = 1 (visible).
- Reset release:
  - First rising edge with reset_n=1 registers the decoded inputs.
  - The counter starts counting from 0 on that same edge.
- Latency: one clock. A change on any of dk, blank, cursor or blink_en at edge N is visible on HEX after edge N+1. The path is combinational from inputs to the output register, with no further pipelining.
- Blink period:
  - phase toggles once every BLINK_DIV cycles; full blink period is 2·BLINK_DIV cycles.
  - After reset, the first toggle (to 0, dark) occurs on the BLINK_DIV-th rising edge after release.
  - The HEX output reflects it one cycle later.
- Reset asserted mid-blink: counter and phase return to their reset values; there is no carry-over.
- Input values are 3-bit, so no out-of-range codes exist.

## Test plan
- Reset: hold reset_n=0 with d0..d3=1,2,3,4 → all HEX=0x7F. Release, d0=1, d1=2, d2=3, d3=4, blank=0, blink_en=0 → after 1 edge HEX0=0x79, HEX1=0x24, HEX2=0x30, HEX3=0x19.
- Full decode sweep: drive d0 = 0..7 on consecutive cycles → HEX0 = 0x40, 0x79, 0x24, 0x30, 0x19, 0x12, 0x02, 0x78, each lagging one cycle. Repeat for d1–d3.
- Blanking: d2=5, blank=4'b0100 → HEX2=0x7F while HEX0, HEX1, HEX3 are unaffected. Clear blank → HEX2=0x12 one cycle later.
- Blink (BLINK_DIV=4), cursor=1, d1=6, blink_en=1:
  - HEX1 alternates 0x02 / 0x7F every 4 cycles; first dark after edge 5 post-reset.
  - Other digits stay steady.
  - Switch cursor to 3 mid-dark → HEX1 returns to 0x02 and HEX3 goes dark on the next edge.
- Priority: blank[1]=1 with cursor=1 and blink_en=1 → HEX1 stays 0x7F through both phases.
- Asynchronous reset mid-operation: assert reset_n=0 between clock edges → all HEX=0x7F before the next edge. On release, blink restarts (first dark after BLINK_DIV+1 edges). Also run once with ACTIVE_LOW=0: digit 0 → 0x3F, dark → 0x00.
